// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM state
// encodings, latency counter width and the funct3 legality check.
package mem_pkg;

  localparam int unsigned LAT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  // Unsigned variants exist only for loads.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = we;
      default:          f3_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response channel.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lsu_align.sv
// Byte-lane steering for RV32I loads/stores: store byte enables and lane data,
// load extraction with sign/zero extension, and alignment faults.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata,
  output logic        misalign_err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte        = ram_word[{addr_lo, 3'b000} +: 8];
    rhalf        = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
    byte_en      = '0;
    lane_wdata   = '0;
    rdata        = '0;
    misalign_err = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      end
      F3_H, F3_HU: begin
        misalign_err = addr_lo[0];
        byte_en      = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata   = {2{wdata[15:0]}};
        rdata        = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      end
      F3_W: begin
        misalign_err = (addr_lo != 2'b00);
        byte_en      = '1;
        lane_wdata   = wdata;
        rdata        = ram_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable response
// latency, word RAM with byte lanes committed on entry to RESP.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned      IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]      SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic             ZERO_LAT  = (LATENCY == 0);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  state_t           state;
  logic [LAT_W-1:0] cnt;
  logic             cap_we;
  logic [31:0]      cap_addr, cap_wdata;
  logic [2:0]       cap_f3;
  logic             cur_we;
  logic [31:0]      cur_addr, cur_wdata;
  logic [2:0]       cur_f3;
  logic [31:0]      off, ram_word;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      lane_wdata, ext_rdata;
  logic             misalign_err, acc_err, commit;
  logic [31:0]      rdata_q;
  logic             err_q;

  // With zero latency the commit edge is the accept edge, so the live request
  // feeds the datapath in IDLE; otherwise the captured copy does.
  always_comb begin
    cur_we    = (state == IDLE) ? bus.req_we     : cap_we;
    cur_addr  = (state == IDLE) ? bus.req_addr   : cap_addr;
    cur_wdata = (state == IDLE) ? bus.req_wdata  : cap_wdata;
    cur_f3    = (state == IDLE) ? bus.req_funct3 : cap_f3;
    off       = cur_addr - ADDR_BASE;
    in_range  = ({1'b0, off} < SPAN);
    idx       = off[IDX_W+1:2];
    ram_word  = in_range ? mem[idx] : '0;
    acc_err   = f3_illegal(cur_we, cur_f3) | misalign_err | ~in_range;
    commit    = rst_n && (((state == IDLE) && bus.req_valid && ZERO_LAT) ||
                          ((state == WAIT) && (cnt == '0)));
  end

  lsu_align u_align (
    .funct3       (cur_f3),
    .addr_lo      (cur_addr[1:0]),
    .wdata        (cur_wdata),
    .ram_word     (ram_word),
    .byte_en      (byte_en),
    .lane_wdata   (lane_wdata),
    .rdata        (ext_rdata),
    .misalign_err (misalign_err)
  );

  always_ff @(posedge clk) begin
    if (commit && cur_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_f3    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cap_we    <= bus.req_we;
          cap_addr  <= bus.req_addr;
          cap_wdata <= bus.req_wdata;
          cap_f3    <= bus.req_funct3;
          if (ZERO_LAT) begin
            state <= RESP;
          end else begin
            state <= WAIT;
            cnt   <= LAT_LOAD;
          end
        end
        WAIT: if (cnt == '0) state <= RESP;
              else           cnt   <= cnt - 1'b1;
        RESP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        rdata_q <= (cur_we || acc_err) ? '0 : ext_rdata;
        err_q   <= acc_err;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 3 and 0, one with a
// non-zero base) checked against a byte-addressed reference memory.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int unsigned NI = 3;

  function automatic int unsigned lat_of(input int unsigned i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction
  function automatic int unsigned depth_of(input int unsigned i);
    return (i == 1) ? 64 : 1024;
  endfunction
  function automatic logic [31:0] base_of(input int unsigned i);
    return (i == 1) ? 32'h0000_1000 : 32'h0;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  int unsigned sel = 0;

  logic        rr_a [NI];
  logic        rv_a [NI];
  logic        re_a [NI];
  logic [31:0] rd_a [NI];
  logic        rr, rv, re;
  logic [31:0] rd;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [7:0]  mb [longint];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.req_valid  = req_valid && (sel == g);
    assign bus.req_we     = req_we;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.req_funct3 = req_funct3;
    assign bus.rsp_ready  = rsp_ready && (sel == g);
    assign rr_a[g] = bus.req_ready;
    assign rv_a[g] = bus.rsp_valid;
    assign re_a[g] = bus.rsp_err;
    assign rd_a[g] = bus.rsp_rdata;
    dmem_responder #(
      .DEPTH_WORDS (depth_of(g)),
      .LATENCY     (lat_of(g)),
      .ADDR_BASE   (base_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  assign rr = rr_a[sel];
  assign rv = rv_a[sel];
  assign re = re_a[sel];
  assign rd = rd_a[sel];

  // Reference: memory as individual little-endian bytes keyed by instance and offset.
  task automatic model_access(input int unsigned s, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] f3,
                              output logic [31:0] exp_d, output bit exp_e, output bit known);
    int unsigned size;
    bit sgn;
    longint off, key;
    size = 0; sgn = 0; exp_d = '0; exp_e = 0; known = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    off = longint'(a) - longint'(base_of(s));
    if (size == 0 || (we && size < 4 && !sgn) || (a % size) != 0 ||
        off < 0 || off >= longint'(depth_of(s)) * 4) begin
      exp_e = 1;
      return;
    end
    for (int unsigned i = 0; i < size; i++) begin
      key = (longint'(s) << 32) | (off + longint'(i));
      if (we) mb[key] = wd[8*i +: 8];
      else if (mb.exists(key)) exp_d[8*i +: 8] = mb[key];
      else known = 0;
    end
    if (we) exp_d = '0;
    else if (sgn && size == 1) exp_d = {{24{exp_d[7]}}, exp_d[7:0]};
    else if (sgn && size == 2) exp_d = {{16{exp_d[15]}}, exp_d[15:0]};
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int unsigned hold, input string nm);
    logic [31:0] ed, d0;
    bit ee, kn, e0;
    int unsigned n;
    model_access(sel, we, a, wd, f3, ed, ee, kn);
    total++;
    if (rr !== 1'b1) begin bad++; $display("FAIL %s idle_ready got=%b want=1", nm, rr); end
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(posedge clk); #1;
    // Conflicting request held on the inputs while busy; it must be ignored.
    req_we = 1; req_funct3 = F3_W; req_wdata = $urandom;
    req_addr = base_of(sel) + ($urandom & 32'h0000_00FC);
    n = 0;
    while (rv !== 1'b1 && n < 40) begin
      total++;
      if (rr !== 1'b0) begin bad++; $display("FAIL %s busy_ready got=%b want=0", nm, rr); end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != lat_of(sel)) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, n, lat_of(sel)); end
    if (rv === 1'b1) begin
      total++;
      if (re !== ee) begin bad++; $display("FAIL %s err got=%b want=%b", nm, re, ee); end
      if (kn) begin
        total++;
        if (rd !== ed) begin bad++; $display("FAIL %s rdata got=%h want=%h", nm, rd, ed); end
      end
      d0 = rd; e0 = re;
      for (int unsigned h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        total++;
        if (rv !== 1'b1 || rr !== 1'b0 || rd !== d0 || re !== e0) begin
          bad++;
          $display("FAIL %s stall got v=%b r=%b d=%h e=%b want v=1 r=0 d=%h e=%b", nm, rv, rr, rd, re, d0, e0);
        end
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      total++;
      if (rv !== 1'b0 || rr !== 1'b1) begin
        bad++; $display("FAIL %s release got v=%b r=%b want v=0 r=1", nm, rv, rr);
      end
    end
    req_valid = 0;
  endtask

  task automatic check_reset_vals(input string nm);
    for (int unsigned i = 0; i < NI; i++) begin
      total++;
      if (rr_a[i] !== 1'b1 || rv_a[i] !== 1'b0 || rd_a[i] !== 32'h0 || re_a[i] !== 1'b0) begin
        bad++;
        $display("FAIL %s inst%0d got r=%b v=%b d=%h e=%b want r=1 v=0 d=0 e=0",
                 nm, i, rr_a[i], rv_a[i], rd_a[i], re_a[i]);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_basic();
    sel = 0;
    access(1, 32'h10, 32'hDEADBEEF, F3_W, 0, "sw10");
    access(0, 32'h10, 32'h0, F3_W, 0, "lw10");
    access(0, 32'h13, 32'h0, F3_B, 0, "lb13");
    access(0, 32'h13, 32'h0, F3_BU, 0, "lbu13");
    access(0, 32'h10, 32'h0, F3_H, 0, "lh10");
    access(0, 32'h12, 32'h0, F3_HU, 0, "lhu12");
    access(1, 32'h11, 32'h000000AA, F3_B, 0, "sb11");
    access(0, 32'h10, 32'h0, F3_W, 0, "lw10_sb");
    access(1, 32'h16, 32'h00005A3C, F3_H, 1, "sh16");
    access(0, 32'h14, 32'h0, F3_HU, 0, "lhu14");
    access(0, 32'h16, 32'h0, F3_H, 0, "lh16");
  endtask

  task automatic test_errors();
    sel = 0;
    access(0, 32'h12, 32'h0, F3_W, 0, "lw_mis");
    access(1, 32'h13, 32'hFFFF, F3_H, 0, "sh_mis");
    access(0, 32'h1000, 32'h0, F3_W, 0, "lw_oor");
    access(0, 32'h10, 32'h0, 3'b011, 0, "f3_011");
    access(1, 32'h10, 32'h0, F3_BU, 0, "sbu_ill");
    access(0, 32'h10, 32'h0, F3_W, 0, "lw_after_err");
    sel = 1;
    access(1, 32'h10FC, 32'h01020304, F3_W, 0, "sw_top");
    access(0, 32'h10FC, 32'h0, F3_W, 0, "lw_top");
    access(0, 32'h1100, 32'h0, F3_W, 0, "lw_end");
    access(1, 32'h0FFC, 32'h0, F3_W, 0, "sw_below");
  endtask

  task automatic test_stall();
    sel = 1;
    access(1, 32'h1040, 32'h89ABCDEF, F3_W, 5, "stall_sw");
    access(0, 32'h1041, 32'h0, F3_B, 5, "stall_lb");
  endtask

  task automatic test_back_to_back();
    sel = 2;
    access(1, 32'h80, 32'h0BADF00D, F3_W, 0, "b2b_sw");
    access(0, 32'h80, 32'h0, F3_W, 0, "b2b_lw");
    access(0, 32'h82, 32'h0, F3_H, 0, "b2b_lh");
  endtask

  task automatic test_reset_wait();
    int unsigned n;
    sel = 0;
    access(1, 32'h20, 32'hCAFEF00D, F3_W, 0, "pre20");
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = F3_W;
    @(posedge clk); #1;
    req_valid = 0;
    total++;
    if (rv !== 1'b0 || rr !== 1'b0) begin bad++; $display("FAIL rst_wait in_wait got v=%b r=%b want 0 0", rv, rr); end
    rst_n = 0;
    #1 check_reset_vals("rst_wait");
    @(posedge clk); #1;
    rst_n = 1;
    access(0, 32'h20, 32'h0, F3_W, 0, "lw20_old");
    sel = 1;
    access(1, 32'h1020, 32'h11111111, F3_W, 0, "pre1020");
    req_valid = 1; req_we = 1; req_addr = 32'h1020; req_wdata = 32'hA5A5A5A5; req_funct3 = F3_W;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (rv !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (rv !== 1'b1) begin bad++; $display("FAIL rst_resp reach got v=%b want 1", rv); end
    rst_n = 0;
    #1 check_reset_vals("rst_resp");
    @(posedge clk); #1;
    rst_n = 1;
    begin
      logic [31:0] d; bit e, k;
      model_access(1, 1, 32'h1020, 32'hA5A5A5A5, F3_W, d, e, k);
    end
    access(0, 32'h1020, 32'h0, F3_W, 0, "lw1020_new");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int unsigned s = 0; s < NI; s++) begin
      sel = s;
      b = base_of(s);
      for (int unsigned w = 0; w < 8; w++) access(1, b + 4*w, $urandom, F3_W, 0, "rinit");
      for (int unsigned k = 0; k < 40; k++) begin
        case ($urandom % 8)
          0: a = b + 32'(depth_of(s)) * 4 + ($urandom % 8);
          1: a = b - 1 - ($urandom % 8);
          default: a = b + ($urandom % 36);
        endcase
        access(1'($urandom % 2), a, $urandom, 3'($urandom % 8), $urandom % 3, "rand");
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts one load or store request at a time and returns read data with RISC-V sign/zero extension.
- Holds a word-organised RAM with byte lanes. Serves LB/LH/LW/LBU/LHU and SB/SH/SW.
- Response latency is programmable, so the core can be exercised against slow memory.
- Sits between the core's to_dmem/fr_dmem path and the data RAM; it replaces the direct wire hookup.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM.
- LATENCY, 1: wait cycles between request accept and response (legal range 0..15).
- ADDR_BASE, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_funct3  in  3  RV32I load/store funct3.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture we, addr, wdata and funct3.
  - From IDLE: go to WAIT when LATENCY>0; go to RESP when LATENCY=0.
  - WAIT: a 4-bit counter is loaded with LATENCY-1 and decrements each cycle. When it reaches 0, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are stable until rsp_ready=1, then go to IDLE.
- req_ready=0 in WAIT and RESP. There is no pipelining; minimum occupancy per access is LATENCY+2 cycles including the IDLE cycle.
- Commit point is the clock edge entering RESP:
  - Stores write the RAM with byte enables.
  - Loads read the RAM and register the extended data into rsp_rdata.
- Address decode:
  - off = addr - ADDR_BASE.
  - word index = off[31:2].
  - Out of range when off >= DEPTH_WORDS*4, including wrap below ADDR_BASE.
- Error when any of the following holds: funct3 in {011,110,111}; store with funct3 in {100,101}; half access with addr[0]=1; word access with addr[1:0]!=0; out of range.
- On error: no RAM write, rsp_rdata=0, rsp_err=1. An error still produces exactly one response.
- Stores:
  - SB: byte enable = 1<<addr[1:0], data replicated on all 4 lanes.
  - SH: byte enable = 4'b0011 or 4'b1100 selected by addr[1], data replicated on both halves.
  - SW: byte enable = 4'b1111.
- Loads: select the byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Input changes while not in IDLE are ignored; captured values are used.
- rsp_ready=1 outside RESP has no effect.
- Reset asserted in WAIT: the access is dropped, no write occurs, state returns to IDLE. Reset asserted in RESP: the response is dropped; the write has already committed.
- Read after write to the same address returns the new data.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state typedef {IDLE, WAIT, RESP}.
  - LAT_W=4.
- One combinational sub-module, lsu_align, is natural. It takes funct3, addr[1:0], wdata and the raw RAM word. It produces byte_en, lane-aligned wdata, extended rdata and misalign_err.
- The RAM array and the FSM live in dmem_responder.

Test Plan:
- Apply reset; LATENCY=1; SW addr 0x10 data 0xDEADBEEF, then LW 0x10. Expected: each response arrives 2 cycles after accept with rsp_err=0, and the LW returns 0xDEADBEEF.
- Over word 0x10 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x000000AA, then LW 0x10. Expected: 0xDEADAAEF, showing only byte lane 1 changed.
- LW 0x12, SH 0x13, LW at ADDR_BASE+4*DEPTH_WORDS, and funct3=011. Expected for each: rsp_err=1, rsp_rdata=0, no RAM change; a following LW 0x10 still returns the prior value.
- LATENCY=3 with rsp_ready held 0 for 5 cycles. Expected: req_ready=0 throughout, rsp_valid held with stable data, IDLE exactly one cycle after rsp_ready=1. Then a back-to-back SW/LW with LATENCY=0 shows 2-cycle occupancy.
- Assert rst_n low mid-WAIT of SW 0x20 data 0x12345678, release, then LW 0x20. Expected: the old value is returned and outputs equal reset values during reset.
